// File: rtl/unidade_writeback_pkg.sv
// Shared types and constants for the register-file write-back unit.
package unidade_writeback_pkg;

    localparam int unsigned LARGURA_DADO = 32;
    localparam int unsigned LARGURA_END  = 5;

    localparam logic [LARGURA_END-1:0] REG_ZERO = LARGURA_END'(0);

    // One queued register-file write.
    typedef struct packed {
        logic                    valido;
        logic [LARGURA_END-1:0]  rd;
        logic [LARGURA_DADO-1:0] dado;
    } entrada_t;

endpackage

// File: rtl/unidade_writeback_if.sv
// Bundle of the write-back unit's handshake, register-file and scoreboard signals.
//   slave  : the write-back unit (consumes results, drives the register file port)
//   master : producers / decode / register file side
interface unidade_writeback_if #(
    parameter int unsigned PROFUNDIDADE = 4
) ();
    import unidade_writeback_pkg::*;

    localparam int unsigned LARGURA_OCUP = $clog2(PROFUNDIDADE) + 1;

    logic                    alu_valido;
    logic                    alu_pronto;
    logic [LARGURA_END-1:0]  alu_rd;
    logic [LARGURA_DADO-1:0] alu_dado;

    logic                    mem_valido;
    logic                    mem_pronto;
    logic [LARGURA_END-1:0]  mem_rd;
    logic [LARGURA_DADO-1:0] mem_dado;

    logic                    RegWrite;
    logic [LARGURA_END-1:0]  r3;
    logic [LARGURA_DADO-1:0] dado_escrita;

    logic [LARGURA_END-1:0]  consulta_rs;
    logic [LARGURA_END-1:0]  consulta_rt;
    logic                    pendente_rs;
    logic                    pendente_rt;
    logic [LARGURA_OCUP-1:0] ocupacao;

    modport slave (
        input  alu_valido, alu_rd, alu_dado,
        input  mem_valido, mem_rd, mem_dado,
        input  consulta_rs, consulta_rt,
        output alu_pronto, mem_pronto,
        output RegWrite, r3, dado_escrita,
        output pendente_rs, pendente_rt, ocupacao
    );

    modport master (
        output alu_valido, alu_rd, alu_dado,
        output mem_valido, mem_rd, mem_dado,
        output consulta_rs, consulta_rt,
        input  alu_pronto, mem_pronto,
        input  RegWrite, r3, dado_escrita,
        input  pendente_rs, pendente_rt, ocupacao
    );

endinterface

// File: rtl/unidade_writeback_fila.sv
// fila_writeback: in-order write FIFO with two ordered push slots and one pop.
//   clock, reset            : clock, synchronous active-high reset
//   push0_i/entrada0_i      : first (older) push slot
//   push1_i/entrada1_i      : second push slot, only meaningful with push0_i
//   pop_i                   : remove head (caller guarantees non-empty)
//   cabeca_rd_o/dado_o      : head entry
//   ocupacao_o              : entry count
//   valido_o/rd_o           : per-slot valid bit and destination for the scoreboard
module fila_writeback
    import unidade_writeback_pkg::*;
#(
    parameter int unsigned PROFUNDIDADE = 4
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     push0_i,
    input  entrada_t                                 entrada0_i,
    input  logic                                     push1_i,
    input  entrada_t                                 entrada1_i,
    input  logic                                     pop_i,
    output logic [LARGURA_END-1:0]                   cabeca_rd_o,
    output logic [LARGURA_DADO-1:0]                  cabeca_dado_o,
    output logic [$clog2(PROFUNDIDADE):0]            ocupacao_o,
    output logic [PROFUNDIDADE-1:0]                  valido_o,
    output logic [PROFUNDIDADE-1:0][LARGURA_END-1:0] rd_o
);

    localparam int unsigned LP = $clog2(PROFUNDIDADE);
    localparam int unsigned LO = LP + 1;
    localparam int unsigned LS = LO + 1;

    entrada_t          fila_q [PROFUNDIDADE];
    logic [LP-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LP-1:0]     wr_ptr_q, wr_ptr_d, wr_ptr_seg;
    logic [LO-1:0]     ocup_q, ocup_d;
    logic [LS-1:0]     soma;

    // Pointer / count next-state; power-of-two depth makes pointer wrap free.
    always_comb begin
        wr_ptr_seg = wr_ptr_q + LP'(1);
        rd_ptr_d   = pop_i ? rd_ptr_q + LP'(1) : rd_ptr_q;
        wr_ptr_d   = wr_ptr_q + LP'(push0_i) + LP'(push1_i);
        soma       = LS'(ocup_q) + LS'(push0_i) + LS'(push1_i) - LS'(pop_i);
        ocup_d     = soma[LO-1:0];
    end

    // Storage; a push into the slot being popped (full case) wins over the valid clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            ocup_q   <= '0;
            for (int unsigned i = 0; i < PROFUNDIDADE; i++) begin
                fila_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            ocup_q   <= ocup_d;
            if (pop_i) begin
                fila_q[rd_ptr_q].valido <= 1'b0;
            end
            if (push0_i) begin
                fila_q[wr_ptr_q] <= entrada0_i;
            end
            if (push1_i) begin
                fila_q[wr_ptr_seg] <= entrada1_i;
            end
        end
    end

    // Count must never pass the depth.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (soma <= LS'(PROFUNDIDADE));
        end
    end

    always_comb begin
        cabeca_rd_o   = fila_q[rd_ptr_q].rd;
        cabeca_dado_o = fila_q[rd_ptr_q].dado;
        ocupacao_o    = ocup_q;
        for (int unsigned i = 0; i < PROFUNDIDADE; i++) begin
            valido_o[i] = fila_q[i].valido;
            rd_o[i]     = fila_q[i].rd;
        end
    end

endmodule

// File: rtl/unidade_writeback.sv
// unidade_writeback: accepts ALU and load results, queues them in order and
// drives the register-file write port at one write per clock, with a
// pending-destination scoreboard for decode.
//   clock, reset : clock, synchronous active-high reset
//   bus (slave)  : alu/mem valid-ready inputs, RegWrite/r3/dado_escrita,
//                  consulta_rs/rt -> pendente_rs/rt, ocupacao
module unidade_writeback
    import unidade_writeback_pkg::*;
#(
    parameter int unsigned PROFUNDIDADE = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    unidade_writeback_if.slave   bus
);

    localparam int unsigned LO = $clog2(PROFUNDIDADE) + 1;

    logic [LO-1:0]                          ocupacao;
    logic [LO-1:0]                          livre;
    logic                                   mem_pronto, alu_pronto;
    logic                                   mem_push, alu_push, pop;
    entrada_t                               entrada_mem, entrada_alu;
    entrada_t                               entrada0, entrada1;
    logic [LARGURA_END-1:0]                 cabeca_rd;
    logic [LARGURA_DADO-1:0]                cabeca_dado;
    logic [PROFUNDIDADE-1:0]                valido_fila;
    logic [PROFUNDIDADE-1:0][LARGURA_END-1:0] rd_fila;

    logic                    regwrite_q, regwrite_d;
    logic [LARGURA_END-1:0]  r3_q, r3_d;
    logic [LARGURA_DADO-1:0] dado_q, dado_d;

    // Readiness uses the pre-edge count, so a same-edge pop is never credited.
    // When a real load also arrives the ALU needs room for two entries.
    always_comb begin
        livre      = LO'(PROFUNDIDADE) - ocupacao;
        mem_pronto = (livre != '0);
        if (bus.mem_valido && (bus.mem_rd != REG_ZERO)) begin
            alu_pronto = (livre >= LO'(2));
        end else begin
            alu_pronto = (livre != '0);
        end
    end

    // Handshake + $zero filter; the load is older, so it takes slot 0.
    always_comb begin
        mem_push    = bus.mem_valido && mem_pronto && (bus.mem_rd != REG_ZERO);
        alu_push    = bus.alu_valido && alu_pronto && (bus.alu_rd != REG_ZERO);
        entrada_mem = '{valido: 1'b1, rd: bus.mem_rd, dado: bus.mem_dado};
        entrada_alu = '{valido: 1'b1, rd: bus.alu_rd, dado: bus.alu_dado};
        entrada0    = mem_push ? entrada_mem : entrada_alu;
        entrada1    = entrada_alu;
        pop         = (ocupacao != '0);
    end

    fila_writeback #(
        .PROFUNDIDADE (PROFUNDIDADE)
    ) u_fila (
        .clock         (clock),
        .reset         (reset),
        .push0_i       (mem_push || alu_push),
        .entrada0_i    (entrada0),
        .push1_i       (mem_push && alu_push),
        .entrada1_i    (entrada1),
        .pop_i         (pop),
        .cabeca_rd_o   (cabeca_rd),
        .cabeca_dado_o (cabeca_dado),
        .ocupacao_o    (ocupacao),
        .valido_o      (valido_fila),
        .rd_o          (rd_fila)
    );

    // Write port: one pulse per popped entry, address/data hold otherwise.
    always_comb begin
        regwrite_d = pop;
        r3_d       = r3_q;
        dado_d     = dado_q;
        if (pop) begin
            r3_d   = cabeca_rd;
            dado_d = cabeca_dado;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            regwrite_q <= 1'b0;
            r3_q       <= '0;
            dado_q     <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            r3_q       <= r3_d;
            dado_q     <= dado_d;
        end
    end

    // Scoreboard over queued entries only: the popped entry already has its valid cleared.
    always_comb begin
        bus.pendente_rs = 1'b0;
        bus.pendente_rt = 1'b0;
        for (int unsigned i = 0; i < PROFUNDIDADE; i++) begin
            if (valido_fila[i] && (rd_fila[i] == bus.consulta_rs)) bus.pendente_rs = 1'b1;
            if (valido_fila[i] && (rd_fila[i] == bus.consulta_rt)) bus.pendente_rt = 1'b1;
        end
        if (bus.consulta_rs == REG_ZERO) bus.pendente_rs = 1'b0;
        if (bus.consulta_rt == REG_ZERO) bus.pendente_rt = 1'b0;
    end

    assign bus.mem_pronto   = mem_pronto;
    assign bus.alu_pronto   = alu_pronto;
    assign bus.RegWrite     = regwrite_q;
    assign bus.r3           = r3_q;
    assign bus.dado_escrita = dado_q;
    assign bus.ocupacao     = ocupacao;

endmodule

// File: tb/tb_unidade_writeback.sv
// Directed bench for unidade_writeback: cycle table for the dual-source burst
// plus hand-written sequences for latency, $zero, ordering, scoreboard and reset.
module tb_unidade_writeback;
    import unidade_writeback_pkg::*;

    localparam int unsigned PROF = 4;

    logic clock;
    logic reset;

    unidade_writeback_if #(.PROFUNDIDADE(PROF)) bus ();

    unidade_writeback #(.PROFUNDIDADE(PROF)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks;
    int errors;
    logic [31:0] regs [32];
    int escritas_zero;
    int escritas_descartadas;
    bit monit_descarte;

    // Register file model: commits on the falling edge inside the RegWrite cycle.
    always @(negedge clock) begin
        if (bus.RegWrite === 1'b1) begin
            if (bus.r3 == 5'd0) escritas_zero++;
            else regs[bus.r3] = bus.dado_escrita;
            if (monit_descarte && bus.r3 >= 5'd10 && bus.r3 <= 5'd12) escritas_descartadas++;
        end
    end

    typedef struct {
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic [2:0]  occ;
        logic        mp;
        logic        ap;
        logic        rw;
        logic [4:0]  r3;
        logic [31:0] dado;
    } vetor_t;

    vetor_t tab [10];

    function automatic vetor_t mk(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                                  input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                  input logic [2:0] occ, input logic mp, input logic ap,
                                  input logic rw, input logic [4:0] r3, input logic [31:0] dado);
        vetor_t v;
        v.mv = mv; v.mrd = mrd; v.md = md;
        v.av = av; v.ard = ard; v.ad = ad;
        v.occ = occ; v.mp = mp; v.ap = ap;
        v.rw = rw; v.r3 = r3; v.dado = dado;
        return v;
    endfunction

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nome, atual, esperado);
        end
    endtask

    task automatic idle();
        bus.mem_valido = 1'b0; bus.mem_rd = 5'd0; bus.mem_dado = 32'h0;
        bus.alu_valido = 1'b0; bus.alu_rd = 5'd0; bus.alu_dado = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        escritas_zero = 0;
        escritas_descartadas = 0;
        monit_descarte = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        reset = 1'b1;
        idle();
        bus.consulta_rs = 5'd0;
        bus.consulta_rt = 5'd0;

        // Both sources offering every cycle. A pop happens at every edge with
        // a non-empty queue, so the count settles at 3 and mem_pronto stays high.
        // Accept order 1,2,3,4,5,7,(0 dropped),6 -> writes 1,2,3,4,5,7,6.
        tab[0] = mk(1, 5'd1, 32'h1000_0001, 1, 5'd2, 32'h2000_0002, 3'd0, 1, 1, 0, 5'd0, 32'h0);
        tab[1] = mk(1, 5'd3, 32'h1000_0003, 1, 5'd4, 32'h2000_0004, 3'd2, 1, 1, 0, 5'd0, 32'h0);
        tab[2] = mk(1, 5'd5, 32'h1000_0005, 1, 5'd6, 32'h2000_0006, 3'd3, 1, 0, 1, 5'd1, 32'h1000_0001);
        tab[3] = mk(1, 5'd7, 32'h1000_0007, 1, 5'd6, 32'h2000_0006, 3'd3, 1, 0, 1, 5'd2, 32'h2000_0002);
        tab[4] = mk(1, 5'd0, 32'h0000_1234, 1, 5'd6, 32'h2000_0006, 3'd3, 1, 1, 1, 5'd3, 32'h1000_0003);
        tab[5] = mk(0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         3'd3, 1, 1, 1, 5'd4, 32'h2000_0004);
        tab[6] = mk(0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         3'd2, 1, 1, 1, 5'd5, 32'h1000_0005);
        tab[7] = mk(0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         3'd1, 1, 1, 1, 5'd7, 32'h1000_0007);
        tab[8] = mk(0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         3'd0, 1, 1, 1, 5'd6, 32'h2000_0006);
        tab[9] = mk(0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         3'd0, 1, 1, 0, 5'd6, 32'h2000_0006);

        // Reset state
        do_reset();
        @(negedge clock);
        chk("rst ocupacao", 32'(bus.ocupacao), 32'd0);
        chk("rst RegWrite", 32'(bus.RegWrite), 32'd0);
        chk("rst r3", 32'(bus.r3), 32'd0);
        chk("rst dado_escrita", bus.dado_escrita, 32'h0);
        chk("rst mem_pronto", 32'(bus.mem_pronto), 32'd1);
        chk("rst alu_pronto", 32'(bus.alu_pronto), 32'd1);
        next_cycle();

        // Burst table
        for (int i = 0; i < 10; i++) begin
            bus.mem_valido = tab[i].mv; bus.mem_rd = tab[i].mrd; bus.mem_dado = tab[i].md;
            bus.alu_valido = tab[i].av; bus.alu_rd = tab[i].ard; bus.alu_dado = tab[i].ad;
            @(negedge clock);
            chk($sformatf("burst[%0d] ocupacao", i), 32'(bus.ocupacao), 32'(tab[i].occ));
            chk($sformatf("burst[%0d] mem_pronto", i), 32'(bus.mem_pronto), 32'(tab[i].mp));
            chk($sformatf("burst[%0d] alu_pronto", i), 32'(bus.alu_pronto), 32'(tab[i].ap));
            chk($sformatf("burst[%0d] RegWrite", i), 32'(bus.RegWrite), 32'(tab[i].rw));
            chk($sformatf("burst[%0d] r3", i), 32'(bus.r3), 32'(tab[i].r3));
            chk($sformatf("burst[%0d] dado", i), bus.dado_escrita, tab[i].dado);
            next_cycle();
        end
        idle();
        chk("burst reg6", regs[6], 32'h2000_0006);
        chk("burst reg7", regs[7], 32'h1000_0007);

        // Single ALU write: one-cycle pulse one cycle after accept
        do_reset();
        bus.alu_valido = 1'b1; bus.alu_rd = 5'd5; bus.alu_dado = 32'hDEAD_BEEF;
        @(negedge clock);
        chk("alu1 alu_pronto", 32'(bus.alu_pronto), 32'd1);
        next_cycle();
        idle();
        @(negedge clock);
        chk("alu1 RegWrite early", 32'(bus.RegWrite), 32'd0);
        chk("alu1 ocupacao", 32'(bus.ocupacao), 32'd1);
        next_cycle();
        @(negedge clock);
        chk("alu1 RegWrite", 32'(bus.RegWrite), 32'd1);
        chk("alu1 r3", 32'(bus.r3), 32'd5);
        chk("alu1 dado", bus.dado_escrita, 32'hDEAD_BEEF);
        next_cycle();
        @(negedge clock);
        chk("alu1 RegWrite after", 32'(bus.RegWrite), 32'd0);
        chk("alu1 r3 hold", 32'(bus.r3), 32'd5);
        next_cycle();
        chk("alu1 reg5", regs[5], 32'hDEAD_BEEF);

        // Load to $zero: handshake completes, nothing queued or written
        bus.mem_valido = 1'b1; bus.mem_rd = 5'd0; bus.mem_dado = 32'h0000_1234;
        @(negedge clock);
        chk("zero mem_pronto", 32'(bus.mem_pronto), 32'd1);
        next_cycle();
        idle();
        @(negedge clock);
        chk("zero ocupacao", 32'(bus.ocupacao), 32'd0);
        chk("zero RegWrite", 32'(bus.RegWrite), 32'd0);
        next_cycle();
        @(negedge clock);
        chk("zero RegWrite later", 32'(bus.RegWrite), 32'd0);
        next_cycle();

        // Same-edge accept: load (older) writes first
        bus.mem_valido = 1'b1; bus.mem_rd = 5'd3; bus.mem_dado = 32'h11;
        bus.alu_valido = 1'b1; bus.alu_rd = 5'd3; bus.alu_dado = 32'h22;
        @(negedge clock);
        chk("pair mem_pronto", 32'(bus.mem_pronto), 32'd1);
        chk("pair alu_pronto", 32'(bus.alu_pronto), 32'd1);
        next_cycle();
        idle();
        @(negedge clock);
        chk("pair ocupacao", 32'(bus.ocupacao), 32'd2);
        chk("pair RegWrite early", 32'(bus.RegWrite), 32'd0);
        next_cycle();
        @(negedge clock);
        chk("pair first RegWrite", 32'(bus.RegWrite), 32'd1);
        chk("pair first r3", 32'(bus.r3), 32'd3);
        chk("pair first dado", bus.dado_escrita, 32'h11);
        next_cycle();
        @(negedge clock);
        chk("pair second RegWrite", 32'(bus.RegWrite), 32'd1);
        chk("pair second r3", 32'(bus.r3), 32'd3);
        chk("pair second dado", bus.dado_escrita, 32'h22);
        next_cycle();
        @(negedge clock);
        chk("pair RegWrite after", 32'(bus.RegWrite), 32'd0);
        next_cycle();
        chk("pair reg3", regs[3], 32'h22);

        // Scoreboard on rd=7
        bus.consulta_rs = 5'd7; bus.consulta_rt = 5'd0;
        bus.alu_valido = 1'b1; bus.alu_rd = 5'd7; bus.alu_dado = 32'h77;
        @(negedge clock);
        chk("sb pend_rs before accept", 32'(bus.pendente_rs), 32'd0);
        next_cycle();
        idle();
        @(negedge clock);
        chk("sb pend_rs queued", 32'(bus.pendente_rs), 32'd1);
        chk("sb pend_rt queued", 32'(bus.pendente_rt), 32'd0);
        next_cycle();
        @(negedge clock);
        chk("sb RegWrite", 32'(bus.RegWrite), 32'd1);
        chk("sb r3", 32'(bus.r3), 32'd7);
        chk("sb pend_rs on port", 32'(bus.pendente_rs), 32'd0);
        chk("sb pend_rt on port", 32'(bus.pendente_rt), 32'd0);
        next_cycle();
        @(negedge clock);
        chk("sb pend_rs after", 32'(bus.pendente_rs), 32'd0);
        next_cycle();

        // Reset mid-burst: queued 10,11,12 are discarded
        bus.consulta_rs = 5'd10; bus.consulta_rt = 5'd11;
        bus.mem_valido = 1'b1; bus.mem_rd = 5'd9;  bus.mem_dado = 32'h99;
        bus.alu_valido = 1'b1; bus.alu_rd = 5'd10; bus.alu_dado = 32'hAA;
        next_cycle();
        bus.mem_rd = 5'd11; bus.mem_dado = 32'hBB;
        bus.alu_rd = 5'd12; bus.alu_dado = 32'hCC;
        @(negedge clock);
        chk("rstmid alu_pronto", 32'(bus.alu_pronto), 32'd1);
        next_cycle();
        monit_descarte = 1'b1;
        reset = 1'b1;
        idle();
        @(negedge clock);
        chk("rstmid ocupacao before", 32'(bus.ocupacao), 32'd3);
        chk("rstmid pend_rs before", 32'(bus.pendente_rs), 32'd1);
        chk("rstmid pend_rt before", 32'(bus.pendente_rt), 32'd1);
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        chk("rstmid RegWrite", 32'(bus.RegWrite), 32'd0);
        chk("rstmid ocupacao", 32'(bus.ocupacao), 32'd0);
        chk("rstmid mem_pronto", 32'(bus.mem_pronto), 32'd1);
        chk("rstmid alu_pronto", 32'(bus.alu_pronto), 32'd1);
        chk("rstmid pend_rs", 32'(bus.pendente_rs), 32'd0);
        chk("rstmid pend_rt", 32'(bus.pendente_rt), 32'd0);
        for (int i = 0; i < 6; i++) next_cycle();
        chk("rstmid discarded writes", 32'(escritas_descartadas), 32'd0);
        chk("rstmid reg10", regs[10], 32'h0);
        chk("writes to zero", 32'(escritas_zero), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
